rice_core_decode_stage: RTL and testbench
=========================================

Name: rice_core_decode_stage

Overview:
Pipeline decode stage for the rice core. It accepts fetched RV32I instructions over a valid/ready handshake and decodes the ALU-class subset: LUI, AUIPC, OP-IMM (ADDI/XORI/ORI/ANDI) and OP (ADD/SUB/XOR/OR/AND). It produces register indices, a sign-extended immediate and a rice_core_alu_operation that drives the execute-stage ALU directly. One registered output stage provides backpressure and flush.

Parameters:
XLEN, 32, data/PC width; only 32 is supported (RV32I immediates).

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous reset, active-high
i_flush  input  1  discard held and incoming instruction
i_valid  input  1  fetch presents an instruction
o_ready  output  1  stage can accept an instruction
i_pc  input  XLEN  instruction PC
i_inst  input  32  instruction word
o_valid  output  1  decoded instruction valid
i_ready  input  1  execute accepts the decoded instruction
o_pc  output  XLEN  registered PC
o_rd  output  5  destination index
o_rs1  output  5  source-1 index
o_rs2  output  5  source-2 index
o_imm  output  XLEN  decoded immediate
o_alu_operation  output  rice_core_alu_operation  command plus source_1/source_2 selects
o_rd_write  output  1  rd is written (0 when rd==0 or illegal)
o_illegal  output  1  opcode/funct not in supported subset

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-high. On reset, all outputs are 0 except o_ready: o_valid=0, o_pc/o_rd/o_rs1/o_rs2/o_imm=0, o_rd_write=0, o_illegal=0, o_alu_operation={ADD, NONE, NONE}.
- o_ready = !o_valid || i_ready (combinational; no dependence on i_valid).
- Transfer in: i_valid && o_ready && !i_flush. Output registers load on the next edge with the decode; o_valid becomes 1. Latency is 1 cycle.
- Transfer out: o_valid && i_ready. With no new transfer in, o_valid becomes 0 on the next edge.
- Simultaneous transfer in and out: the register reloads and o_valid stays 1 (full throughput, 1 instruction/cycle).
- Stall: o_valid && !i_ready. All outputs hold stable; inputs are ignored.
- i_flush has priority. On the next edge o_valid=0 and any input in that cycle is dropped. Data registers may keep their stale values.
- Payload registers update only on transfer in.
- Decode, by opcode bits [6:0]:
  - LUI 0110111: imm=U-type, ADD, src1 NONE, src2 IMM.
  - AUIPC 0010111: imm=U-type, ADD, src1 PC, src2 IMM.
  - OP-IMM 0010011: imm=I-type sign-extended, src1 RS, src2 IMM. funct3 000 ADD, 100 XOR, 110 OR, 111 AND; other funct3 is illegal.
  - OP 0110011: imm=0, src1 RS, src2 RS. {funct7,funct3} 0000000_000 ADD, 0100000_000 SUB, 0000000_100 XOR, 0000000_110 OR, 0000000_111 AND; others are illegal.
  - Any other opcode, or inst[1:0]!=11: illegal.
- Illegal encodings: o_illegal=1, o_rd_write=0, alu_operation={ADD, NONE, NONE}, imm=0. o_valid still asserts so downstream can trap.
- o_rd/o_rs1/o_rs2 are always the raw fields inst[11:7]/[19:15]/[24:20], regardless of format.
- o_rd_write=1 only for legal instructions with rd!=0.
- U-type imm = {inst[31:12],12'b0}. I-type imm = sign-extension of inst[31:20].

Decomposition:
- rice_core_pkg gains or owns these items:
  - rice_core_alu_command enum: ADD, SUB, AND, OR, XOR.
  - rice_core_alu_source enum: NONE, RS, PC, IMM.
  - rice_core_alu_operation struct: command, source_1, source_2.
  - Opcode localparams RICE_CORE_OPCODE_LUI/AUIPC/OP_IMM/OP.
- One combinational sub-module is natural: rice_core_decoder (i_inst -> imm, alu_operation, illegal, rd_write). The stage module adds the handshake register and flush.

Test Plan:
- ADDI x1,x0,5 (0x00500093) at PC 0x100 -> one cycle later:
  - o_valid=1, o_pc=0x100, o_rd=1, o_rs1=0.
  - o_imm=0x00000005, {ADD, RS, IMM}, o_rd_write=1, o_illegal=0.
- Back-to-back stream with i_ready=1:
  - SUB x3,x1,x2 (0x402081B3) -> {SUB, RS, RS}, rd=3, rs1=1, rs2=2, imm=0.
  - LUI x5,0x12345 (0x123452B7) -> imm=0x12345000, {ADD, NONE, IMM}.
  - AUIPC x6,1 (0x00001317) -> imm=0x00001000, {ADD, PC, IMM}.
  - Required: o_valid continuously 1, o_ready continuously 1.
- ANDI x7,x1,-1 (0xFFF0F393) -> o_imm=0xFFFFFFFF, {AND, RS, IMM}.
- Illegal encodings: SLLI x1,x1,1 (0x00109093) and opcode 0x0000006F (JAL) -> o_valid=1, o_illegal=1, o_rd_write=0, {ADD, NONE, NONE}.
- Backpressure: hold i_ready=0 for 3 cycles with i_valid=1 ->
  - o_ready=0 and outputs stable for those cycles.
  - Raise i_ready: the held instruction retires, then the next is loaded the same cycle with no loss or duplication.
- Flush and reset:
  - i_flush with i_valid=1 while o_valid=1 -> next cycle o_valid=0 and the flushed input is never presented.
  - Assert i_rst asynchronously mid-stream -> o_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared types and constants for the rice core pipeline.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: ALU command/source enums, ALU operation struct, RV32I opcodes.
package rice_core_pkg;

  localparam logic [6:0] RICE_CORE_OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] RICE_CORE_OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] RICE_CORE_OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] RICE_CORE_OPCODE_OP     = 7'b0110011;

  // ADD and NONE encode as zero so a cleared register reads {ADD, NONE, NONE}.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } rice_core_alu_command;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RS   = 2'd1,
    SRC_PC   = 2'd2,
    SRC_IMM  = 2'd3
  } rice_core_alu_source;

  typedef struct packed {
    rice_core_alu_command command;
    rice_core_alu_source  source_1;
    rice_core_alu_source  source_2;
  } rice_core_alu_operation;

  localparam rice_core_alu_operation RICE_CORE_ALU_NOP = '{ALU_ADD, SRC_NONE, SRC_NONE};

endpackage

// File: rtl/rice_core_decoder.sv
// rice_core_decoder: combinational RV32I decode of the ALU subset (LUI/AUIPC/OP-IMM/OP).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows i_inst.
// Ports: i_inst in; o_imm, o_alu_operation, o_illegal, o_rd_write out.
module rice_core_decoder
  import rice_core_pkg::*;
(
  input  logic [31:0]            i_inst,
  output logic [31:0]            o_imm,
  output rice_core_alu_operation o_alu_operation,
  output logic                   o_illegal,
  output logic                   o_rd_write
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [31:0] imm_u;
  logic [31:0] imm_i;

  assign opcode = i_inst[6:0];
  assign funct3 = i_inst[14:12];
  assign funct7 = i_inst[31:25];
  assign rd     = i_inst[11:7];
  assign imm_u  = {i_inst[31:12], 12'b0};
  assign imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};

  // Every supported opcode ends in 2'b11, so a full 7-bit compare also
  // rejects compressed encodings (inst[1:0] != 11).
  always_comb begin
    o_imm           = '0;
    o_alu_operation = RICE_CORE_ALU_NOP;
    o_illegal       = 1'b1;
    case (opcode)
      RICE_CORE_OPCODE_LUI: begin
        o_imm           = imm_u;
        o_alu_operation = '{ALU_ADD, SRC_NONE, SRC_IMM};
        o_illegal       = 1'b0;
      end
      RICE_CORE_OPCODE_AUIPC: begin
        o_imm           = imm_u;
        o_alu_operation = '{ALU_ADD, SRC_PC, SRC_IMM};
        o_illegal       = 1'b0;
      end
      RICE_CORE_OPCODE_OP_IMM: begin
        o_illegal = 1'b0;
        case (funct3)
          3'b000:  o_alu_operation = '{ALU_ADD, SRC_RS, SRC_IMM};
          3'b100:  o_alu_operation = '{ALU_XOR, SRC_RS, SRC_IMM};
          3'b110:  o_alu_operation = '{ALU_OR,  SRC_RS, SRC_IMM};
          3'b111:  o_alu_operation = '{ALU_AND, SRC_RS, SRC_IMM};
          default: o_illegal = 1'b1;
        endcase
        // Illegal encodings must present imm=0 and the NOP operation.
        if (!o_illegal) o_imm = imm_i;
      end
      RICE_CORE_OPCODE_OP: begin
        o_illegal = 1'b0;
        case ({funct7, funct3})
          10'b0000000_000: o_alu_operation = '{ALU_ADD, SRC_RS, SRC_RS};
          10'b0100000_000: o_alu_operation = '{ALU_SUB, SRC_RS, SRC_RS};
          10'b0000000_100: o_alu_operation = '{ALU_XOR, SRC_RS, SRC_RS};
          10'b0000000_110: o_alu_operation = '{ALU_OR,  SRC_RS, SRC_RS};
          10'b0000000_111: o_alu_operation = '{ALU_AND, SRC_RS, SRC_RS};
          default:         o_illegal = 1'b1;
        endcase
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  assign o_rd_write = !o_illegal && (rd != 5'd0);

endmodule

// File: rtl/rice_core_decode_stage.sv
// rice_core_decode_stage: decode stage, one registered output slot between fetch and execute.
// Latency: 1 cycle from accepted instruction to o_valid; 1 instruction/cycle sustained.
// Backpressure: o_ready = !o_valid || i_ready; a held slot stays stable; i_flush drops held and incoming.
// Ports: i_clk/i_rst; fetch side i_valid/o_ready/i_pc/i_inst; execute side o_valid/i_ready and
//        decoded payload o_pc/o_rd/o_rs1/o_rs2/o_imm/o_alu_operation/o_rd_write/o_illegal.
module rice_core_decode_stage
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is meaningful (RV32I immediates)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [XLEN-1:0]        i_pc,
  input  logic [31:0]            i_inst,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [XLEN-1:0]        o_pc,
  output logic [4:0]             o_rd,
  output logic [4:0]             o_rs1,
  output logic [4:0]             o_rs2,
  output logic [XLEN-1:0]        o_imm,
  output rice_core_alu_operation o_alu_operation,
  output logic                   o_rd_write,
  output logic                   o_illegal
);

  logic [31:0]            dec_imm;
  rice_core_alu_operation dec_alu_operation;
  logic                   dec_illegal;
  logic                   dec_rd_write;
  logic                   load;

  rice_core_decoder u_decoder (
    .i_inst          (i_inst),
    .o_imm           (dec_imm),
    .o_alu_operation (dec_alu_operation),
    .o_illegal       (dec_illegal),
    .o_rd_write      (dec_rd_write)
  );

  assign o_ready = !o_valid || i_ready;
  assign load    = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid         <= 1'b0;
      o_pc            <= '0;
      o_rd            <= '0;
      o_rs1           <= '0;
      o_rs2           <= '0;
      o_imm           <= '0;
      o_alu_operation <= RICE_CORE_ALU_NOP;
      o_rd_write      <= 1'b0;
      o_illegal       <= 1'b0;
    end else begin
      // Flush wins over both load and retire; payload is left stale.
      if (i_flush)      o_valid <= 1'b0;
      else if (load)    o_valid <= 1'b1;
      else if (i_ready) o_valid <= 1'b0;

      if (load) begin
        o_pc            <= i_pc;
        o_rd            <= i_inst[11:7];
        o_rs1           <= i_inst[19:15];
        o_rs2           <= i_inst[24:20];
        o_imm           <= XLEN'(dec_imm);
        o_alu_operation <= dec_alu_operation;
        o_rd_write      <= dec_rd_write;
        o_illegal       <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_rice_core_decode_stage.sv
// Bench for rice_core_decode_stage: directed instruction stream against a reference model.
// Latency: n/a.
// Backpressure: exercised via i_ready stalls and i_flush.
module tb_rice_core_decode_stage;
  import rice_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst = '0;

  logic                   o_ready, o_valid, o_rd_write, o_illegal;
  logic [31:0]            o_pc, o_imm;
  logic [4:0]             o_rd, o_rs1, o_rs2;
  rice_core_alu_operation o_alu_operation;

  int checks = 0;
  int errors = 0;

  rice_core_decode_stage #(.XLEN(32)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_flush         (flush),
    .i_valid         (in_valid),
    .o_ready         (o_ready),
    .i_pc            (pc),
    .i_inst          (inst),
    .o_valid         (o_valid),
    .i_ready         (out_ready),
    .o_pc            (o_pc),
    .o_rd            (o_rd),
    .o_rs1           (o_rs1),
    .o_rs2           (o_rs2),
    .o_imm           (o_imm),
    .o_alu_operation (o_alu_operation),
    .o_rd_write      (o_rd_write),
    .o_illegal       (o_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]            pc;
    logic [4:0]             rd, rs1, rs2;
    logic [31:0]            imm;
    rice_core_alu_operation op;
    logic                   rd_write;
    logic                   illegal;
  } exp_t;

  // Decode straight from the ISA text: pick the instruction by name, then its format.
  function automatic exp_t ref_decode(input logic [31:0] pc_v, input logic [31:0] w);
    exp_t e;
    string mnem;
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    mnem = "";
    if      (opc == 7'h37) mnem = "lui";
    else if (opc == 7'h17) mnem = "auipc";
    else if (opc == 7'h13 && f3 == 3'd0) mnem = "addi";
    else if (opc == 7'h13 && f3 == 3'd4) mnem = "xori";
    else if (opc == 7'h13 && f3 == 3'd6) mnem = "ori";
    else if (opc == 7'h13 && f3 == 3'd7) mnem = "andi";
    else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd0) mnem = "add";
    else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) mnem = "sub";
    else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd4) mnem = "xor";
    else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd6) mnem = "or";
    else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd7) mnem = "and";
    e.pc  = pc_v;
    e.rd  = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.imm = 32'd0;
    e.op  = '{ALU_ADD, SRC_NONE, SRC_NONE};
    e.illegal = (mnem == "");
    case (mnem)
      "lui":   begin e.imm = w & 32'hFFFFF000; e.op = '{ALU_ADD, SRC_NONE, SRC_IMM}; end
      "auipc": begin e.imm = w & 32'hFFFFF000; e.op = '{ALU_ADD, SRC_PC,   SRC_IMM}; end
      "addi":  begin e.imm = $signed(w) >>> 20; e.op = '{ALU_ADD, SRC_RS, SRC_IMM}; end
      "xori":  begin e.imm = $signed(w) >>> 20; e.op = '{ALU_XOR, SRC_RS, SRC_IMM}; end
      "ori":   begin e.imm = $signed(w) >>> 20; e.op = '{ALU_OR,  SRC_RS, SRC_IMM}; end
      "andi":  begin e.imm = $signed(w) >>> 20; e.op = '{ALU_AND, SRC_RS, SRC_IMM}; end
      "add":   e.op = '{ALU_ADD, SRC_RS, SRC_RS};
      "sub":   e.op = '{ALU_SUB, SRC_RS, SRC_RS};
      "xor":   e.op = '{ALU_XOR, SRC_RS, SRC_RS};
      "or":    e.op = '{ALU_OR,  SRC_RS, SRC_RS};
      "and":   e.op = '{ALU_AND, SRC_RS, SRC_RS};
      default: ;
    endcase
    e.rd_write = !e.illegal && (e.rd != 5'd0);
    return e;
  endfunction

  logic m_valid = 1'b0;
  exp_t m_slot;

  // Slot model: what execute should be looking at after each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
    end else begin
      if (flush) m_valid = 1'b0;
      else if (in_valid && (!m_valid || out_ready)) begin
        m_slot  = ref_decode(pc, inst);
        m_valid = 1'b1;
      end else if (out_ready) m_valid = 1'b0;
    end
  end

  // Compare process: on every falling edge, away from input changes and clock edges.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", 32'(o_valid), 32'(m_valid));
      chk("ready", 32'(o_ready), 32'(!m_valid || out_ready));
      if (m_valid) begin
        chk("pc", o_pc, m_slot.pc);
        chk("rd", 32'(o_rd), 32'(m_slot.rd));
        chk("rs1", 32'(o_rs1), 32'(m_slot.rs1));
        chk("rs2", 32'(o_rs2), 32'(m_slot.rs2));
        chk("imm", o_imm, m_slot.imm);
        chk("alu_op", 32'(o_alu_operation), 32'(m_slot.op));
        chk("rd_write", 32'(o_rd_write), 32'(m_slot.rd_write));
        chk("illegal", 32'(o_illegal), 32'(m_slot.illegal));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] w,
                       input logic rdy, input logic fl);
    in_valid  = v;
    pc        = p;
    inst      = w;
    out_ready = rdy;
    flush     = fl;
  endtask

  localparam rice_core_alu_operation OP_NOP = '{ALU_ADD, SRC_NONE, SRC_NONE};

  initial begin
    // Reset state.
    #3;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_imm", o_imm, 32'd0);
    chk("rst_alu_op", 32'(o_alu_operation), 32'(OP_NOP));
    chk("rst_rd_write", 32'(o_rd_write), 32'd0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);
    #14 rst = 1'b0;  // released at t=17, away from edges
    step();

    // ADDI x1,x0,5
    drive(1, 32'h100, 32'h00500093, 1, 0);
    step();
    chk("addi_valid", 32'(o_valid), 32'd1);
    chk("addi_pc", o_pc, 32'h100);
    chk("addi_rd", 32'(o_rd), 32'd1);
    chk("addi_rs1", 32'(o_rs1), 32'd0);
    chk("addi_imm", o_imm, 32'h5);
    chk("addi_op", 32'(o_alu_operation), 32'({ALU_ADD, SRC_RS, SRC_IMM}));
    chk("addi_rd_write", 32'(o_rd_write), 32'd1);
    chk("addi_illegal", 32'(o_illegal), 32'd0);

    // Back-to-back SUB, LUI, AUIPC.
    drive(1, 32'h104, 32'h402081B3, 1, 0);
    step();
    chk("sub_op", 32'(o_alu_operation), 32'({ALU_SUB, SRC_RS, SRC_RS}));
    chk("sub_regs", {17'd0, o_rd, o_rs1, o_rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
    chk("sub_imm", o_imm, 32'd0);
    chk("sub_vr", {30'd0, o_valid, o_ready}, 32'd3);
    drive(1, 32'h108, 32'h123452B7, 1, 0);
    step();
    chk("lui_imm", o_imm, 32'h12345000);
    chk("lui_op", 32'(o_alu_operation), 32'({ALU_ADD, SRC_NONE, SRC_IMM}));
    chk("lui_vr", {30'd0, o_valid, o_ready}, 32'd3);
    drive(1, 32'h10C, 32'h00001317, 1, 0);
    step();
    chk("auipc_imm", o_imm, 32'h00001000);
    chk("auipc_op", 32'(o_alu_operation), 32'({ALU_ADD, SRC_PC, SRC_IMM}));
    chk("auipc_vr", {30'd0, o_valid, o_ready}, 32'd3);

    // ANDI x7,x1,-1
    drive(1, 32'h110, 32'hFFF0F393, 1, 0);
    step();
    chk("andi_imm", o_imm, 32'hFFFFFFFF);
    chk("andi_op", 32'(o_alu_operation), 32'({ALU_AND, SRC_RS, SRC_IMM}));

    // Illegal: SLLI and JAL.
    drive(1, 32'h114, 32'h00109093, 1, 0);
    step();
    chk("slli_flags", {29'd0, o_valid, o_illegal, o_rd_write}, 32'b110);
    chk("slli_op", 32'(o_alu_operation), 32'(OP_NOP));
    chk("slli_imm", o_imm, 32'd0);
    drive(1, 32'h118, 32'h0000006F, 1, 0);
    step();
    chk("jal_flags", {29'd0, o_valid, o_illegal, o_rd_write}, 32'b110);
    chk("jal_op", 32'(o_alu_operation), 32'(OP_NOP));

    // Backpressure: ADD x8 loads, then XOR x9 waits three stalled cycles.
    drive(1, 32'h200, 32'h00208433, 1, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h204, 32'h0020C4B3, 0, 0);
      if (i > 0) step();
      else #1;
      chk("stall_ready", 32'(o_ready), 32'd0);
      chk("stall_pc", o_pc, 32'h200);
      chk("stall_rd", 32'(o_rd), 32'd8);
    end
    step();
    drive(1, 32'h204, 32'h0020C4B3, 1, 0);
    #1;
    chk("release_ready", 32'(o_ready), 32'd1);
    step();
    chk("release_pc", o_pc, 32'h204);
    chk("release_rd", 32'(o_rd), 32'd9);
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    chk("drain_valid", 32'(o_valid), 32'd0);

    // Flush: ORI held under stall, then flushed along with an incoming instruction.
    drive(1, 32'h300, 32'h00F0E513, 0, 0);
    step();
    chk("ori_imm", o_imm, 32'h0000000F);
    drive(1, 32'h304, 32'h00208433, 0, 1);
    step();
    chk("flush_valid", 32'(o_valid), 32'd0);
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    chk("flush_dropped", 32'(o_valid), 32'd0);

    // Asynchronous reset mid-stream.
    drive(1, 32'h400, 32'h00500093, 0, 0);
    step();
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'd0);
    chk("async_rst_ready", 32'(o_ready), 32'd1);
    chk("async_rst_op", 32'(o_alu_operation), 32'(OP_NOP));
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    drive(1, 32'h500, 32'h123452B7, 1, 0);
    step();
    chk("post_rst_pc", o_pc, 32'h500);
    drive(0, 32'h0, 32'h0, 1, 0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
